// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus; rebuilds the frame as BCD and binary.
// Optional build macro SEG_DECODE_CHANGE_ONLY_EN: report a frame only when its value differs from the held one.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  digit_sel_in,
    output logic [15:0] bcd_out,
    output logic [13:0] value_out,
    output logic        frame_valid,
    output logic        glyph_err,
    output logic        sel_err
);

    localparam logic [3:0] SETTLE_MAX  = 4'(SETTLE_CYCLES);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [3:0]       sel_q;
    logic [3:0]       stable_cnt;
    logic [3:0]       seen;
    logic [3:0]       seen_next;
    logic [3:0][3:0]  slot;
    logic [1:0]       slot_idx;
    logic             sel_changed;
    logic             one_hot;
    logic             multi_hot;
    logic             sample;
    logic             glyph_ok;
    logic [3:0]       glyph_digit;
    logic             complete;
    logic             sel_fault;
    logic             report;
    logic [13:0]      frame_value;

`ifdef SEG_DECODE_CHANGE_ONLY_EN
    logic reported;
`endif

    always_comb begin
        glyph_ok    = 1'b1;
        glyph_digit = 4'd0;
        case (seg_in)
            7'h3F, 7'h00: glyph_digit = 4'd0;
            7'h06:        glyph_digit = 4'd1;
            7'h5B:        glyph_digit = 4'd2;
            7'h4F:        glyph_digit = 4'd3;
            7'h66:        glyph_digit = 4'd4;
            7'h6D:        glyph_digit = 4'd5;
            7'h7D:        glyph_digit = 4'd6;
            7'h07:        glyph_digit = 4'd7;
            7'h7F:        glyph_digit = 4'd8;
            7'h6F:        glyph_digit = 4'd9;
            default:      glyph_ok    = 1'b0;
        endcase
    end

    always_comb begin
        slot_idx = 2'd0;
        case (digit_sel_in)
            4'b0010: slot_idx = 2'd1;
            4'b0100: slot_idx = 2'd2;
            4'b1000: slot_idx = 2'd3;
            default: slot_idx = 2'd0;
        endcase
    end

    assign sel_changed = (digit_sel_in != sel_q);
    assign one_hot     = $onehot(digit_sel_in);
    assign multi_hot   = !$onehot0(digit_sel_in);
    // A dwell samples once: the counter saturates past the sampling point until the select changes.
    assign sample      = one_hot && !sel_changed && (stable_cnt == SETTLE_LAST);
    assign sel_fault   = multi_hot && sel_changed;
    assign complete    = (seen == 4'hF);

    assign frame_value = 14'(slot[3]) * 14'd1000 + 14'(slot[2]) * 14'd100
                       + 14'(slot[1]) * 14'd10 + 14'(slot[0]);

`ifdef SEG_DECODE_CHANGE_ONLY_EN
    assign report = complete && !sel_fault && (!reported || frame_value != value_out);
`else
    assign report = complete && !sel_fault;
`endif

    // A completed frame is consumed even when its report is suppressed or a same-edge sample lands.
    always_comb begin
        seen_next = seen;
        if (complete)
            seen_next = 4'b0000;
        if (sample) begin
            if (glyph_ok)
                seen_next = seen_next | digit_sel_in;
            else
                seen_next = 4'b0000;
        end
        if (sel_fault)
            seen_next = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q       <= 4'd0;
            stable_cnt  <= 4'd0;
            seen        <= 4'd0;
            slot        <= '0;
            bcd_out     <= 16'd0;
            value_out   <= 14'd0;
            frame_valid <= 1'b0;
            glyph_err   <= 1'b0;
            sel_err     <= 1'b0;
`ifdef SEG_DECODE_CHANGE_ONLY_EN
            reported    <= 1'b0;
`endif
        end else begin
            sel_q <= digit_sel_in;
            if (sel_changed)
                stable_cnt <= 4'd0;
            else if (stable_cnt != SETTLE_MAX)
                stable_cnt <= stable_cnt + 4'd1;

            seen        <= seen_next;
            glyph_err   <= sample && !glyph_ok;
            sel_err     <= sel_fault;
            frame_valid <= report;

            if (sample && glyph_ok)
                slot[slot_idx] <= glyph_digit;

            if (report) begin
                bcd_out   <= slot;
                value_out <= frame_value;
`ifdef SEG_DECODE_CHANGE_ONLY_EN
                reported  <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side decoder for the multiplexed 4-digit seven-segment bus driven by the temperature display. It samples `seg_in`/`digit_sel_in` as the display scans and decodes each glyph back to a BCD digit. Once all four digits of a frame have been captured, it reports the reassembled value as BCD and as binary. It sits on the bench/monitor side of the display interface for self-checking, and can serve as a loopback checker in hardware.

## Interface
- `SETTLE_CYCLES`, default 2: consecutive edges a new one-hot select must be held before its glyph is sampled (legal range 1–15).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `seg_in` input 7: segment bus `{g,f,e,d,c,b,a}`, active-high (1 = lit).
- `digit_sel_in` input 4: digit enable, one-hot, active-high; bit 0 = units, bit 3 = thousands; 4'b0000 = blanking gap.
- `bcd_out` output 16: last complete frame as `{thousands,hundreds,tens,units}`.
- `value_out` output 14: binary equivalent of `bcd_out` (0–9999).
- `frame_valid` output 1: one-cycle pulse; `bcd_out`/`value_out` updated in the same cycle.
- `glyph_err` output 1: one-cycle pulse when an undecodable pattern is sampled.
- `sel_err` output 1: one-cycle pulse when `digit_sel_in` is non-zero and not one-hot.

## Operation
- Glyph table (hex of `seg_in`): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Blank (00) decodes as 0, which covers leading-zero suppression. Any other pattern is a glyph error.
- Select tracking:
  - Register `digit_sel_in` every edge.
  - A stability counter resets whenever the input differs from the registered value, and saturates at `SETTLE_CYCLES`.
- Sampling: exactly once per dwell, when the counter reaches `SETTLE_CYCLES` and the select is one-hot.
  - Decoded digit is written to its slot.
  - The slot's `seen` bit is set.
- A dwell of any length never produces a second sample. Re-sampling requires a select change.
- Select 4'b0000: ignored. It resets the counter and does not touch `seen`.
- Multi-hot select: `sel_err` pulses once per multi-hot dwell (on the first edge seen), and `seen` is cleared to 4'b0000.
- Undecodable glyph at sample: `glyph_err` pulses, `seen` is cleared, and the slot keeps its old digit.
- Same digit sampled twice before the frame completes: the slot is overwritten with the newer digit.
- Frame complete when `seen` == 4'b1111:
  - Compute `value_out` = d3·1000 + d2·100 + d1·10 + d0 (14-bit, no overflow possible).
  - Register `bcd_out` and `value_out`, pulse `frame_valid`, clear `seen`.
- Scan order is irrelevant. A frame is any set of four distinct-slot samples without an intervening error.
- Error priority: if `sel_err` and a frame completion would coincide, the error wins and no `frame_valid` is produced.

## Timing
- Let E0 be the first edge at which a new one-hot select is present.
  - The digit slot updates at edge E0+`SETTLE_CYCLES`.
  - `glyph_err` is high in the cycle following that edge.
- `frame_valid`, `bcd_out` and `value_out` are registered one edge after the fourth digit's sample edge.
- `sel_err` is high in the cycle after the first edge that captures the multi-hot value.
- Reset (`reset`=0 at an edge), including mid-frame:
  - `bcd_out`=0, `value_out`=0, `frame_valid`=0, `glyph_err`=0, `sel_err`=0.
  - `seen`=0, digit slots=0, stability counter=0, registered select=0.
  - The first select after reset release counts as a change.
- Glitch of one cycle on `digit_sel_in` shorter than `SETTLE_CYCLES`: no sample, no error unless the glitch value is multi-hot.

## Configuration
- `SEG_DECODE_CHANGE_ONLY_EN`
  - Defined: `frame_valid` (and the output register update) occurs only when the new `value_out` differs from the currently held one. The first complete frame after reset is always reported, even if it equals 0.
  - Undefined: every complete frame pulses `frame_valid`.
- Errors are reported identically in both builds.

## Test plan
- Scan 0000→units `0x4F`, tens `0x5B`, hundreds `0x06`, thousands `0x00`, each held 4 cycles, `SETTLE_CYCLES`=2 -> one `frame_valid`; `bcd_out`=16'h0123, `value_out`=123, pulse one edge after the thousands sample.
- Same frame repeated twice -> two `frame_valid` pulses when built without `SEG_DECODE_CHANGE_ONLY_EN`; one pulse when built with it.
- Tens glyph `0x7E` mid-frame -> `glyph_err` pulse, no `frame_valid` for that scan; next clean scan of 1023 -> `value_out`=1023.
- `digit_sel_in`=4'b0110 for 3 cycles mid-frame -> a single `sel_err` pulse, `seen` cleared, and the frame is completed only by four fresh samples.
- Select held one cycle (< `SETTLE_CYCLES`) -> no sample; select held 20 cycles -> exactly one sample.
- `reset`=0 for one edge after three digits -> all outputs 0; next single digit does not complete a frame.
